// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_sched_pkg : shared FSM states, ALU opcodes and parameter defaults
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_sched_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAKE    = 3'd1,
    ST_READY   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RESP    = 3'd5,
    ST_ISOLATE = 3'd6
  } state_e;

  localparam logic [3:0] OP_ADD     = 4'h0;
  localparam logic [3:0] OP_SUB     = 4'h1;
  localparam logic [3:0] OP_AND     = 4'h2;
  localparam logic [3:0] OP_OR      = 4'h3;
  localparam logic [3:0] OP_XOR     = 4'h4;
  localparam logic [3:0] OP_NAND    = 4'h5;
  localparam logic [3:0] OP_NOR     = 4'h6;
  localparam logic [3:0] OP_XNOR    = 4'h7;
  localparam logic [3:0] OP_MUL     = 4'h8;
  localparam logic [3:0] OP_DIV     = 4'h9;
  localparam logic [3:0] OP_ILL_MIN = 4'hA;

  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int DEF_WAKE_CYCLES  = 2;
  localparam int DEF_WAIT_LIMIT   = 31;

  function automatic logic op_illegal(input logic [3:0] op);
    return op >= OP_ILL_MIN;
  endfunction

  function automatic logic op_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-port round-robin arbiter, pointer advances only on accept
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Index of the port granted last; starts at 1 so port 0 wins the first tie.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|(gnt_o & req_i)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_scheduler : two-requester ALU front end with power/isolation sequencing
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
  parameter int WAIT_LIMIT   = DEF_WAIT_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  output logic        rsp1_err,
  output logic        alu_pwr_en,
  output logic        alu_iso_en,
  output logic        alu_start,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_busy,
  input  logic [15:0] alu_result
);

  localparam int CNT_MAX0 = (IDLE_TIMEOUT > WAIT_LIMIT) ? IDLE_TIMEOUT : WAIT_LIMIT;
  localparam int CNT_MAX  = (CNT_MAX0 > WAKE_CYCLES) ? CNT_MAX0 : WAKE_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             owner_q, owner_d;
  logic [3:0]       op_q, op_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             start_q, pwr_q, iso_q, rsp0_q, rsp1_q;
  logic [1:0]       w_gnt;
  logic             w_accept;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_READY),
    .req_i ({req1_valid, req0_valid}),
    .gnt_o (w_gnt)
  );

  assign w_accept = |(w_gnt & {req1_valid, req0_valid});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_OFF: begin
        if (req0_valid || req1_valid) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: begin
        // Any valid request is granted, so accept also clears the idle count.
        if (w_accept) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
          owner_d = w_gnt[1];
          op_d    = w_gnt[1] ? req1_opcode : req0_opcode;
          a_d     = w_gnt[1] ? req1_a : req0_a;
          b_d     = w_gnt[1] ? req1_b : req0_b;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_ISOLATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end
      ST_WAIT: begin
        seen_d = seen_q | alu_busy;
        if (op_illegal(op_q)) begin
          state_d = ST_RESP;
          data_d  = 16'h0000;
          err_d   = 1'b1;
        end else if (!op_multicycle(op_q) || (seen_q && !alu_busy)) begin
          state_d = ST_RESP;
          data_d  = alu_result;
          err_d   = 1'b0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
          data_d  = 16'h0000;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
      ST_ISOLATE: state_d = ST_OFF;
      default:    state_d = ST_OFF;
    endcase
  end

  // Outputs decode the next state so every port pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= 4'h0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      pwr_q   <= 1'b0;
      iso_q   <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      start_q <= (state_d == ST_ISSUE) && !op_illegal(op_d);
      pwr_q   <= (state_d != ST_OFF);
      iso_q   <= !(state_d inside {ST_READY, ST_ISSUE, ST_WAIT, ST_RESP});
      rsp0_q  <= (state_d == ST_RESP) && !owner_d;
      rsp1_q  <= (state_d == ST_RESP) && owner_d;
    end
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp0_data  = data_q;
  assign rsp1_data  = data_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
  assign alu_pwr_en = pwr_q;
  assign alu_iso_en = iso_q;
  assign alu_start  = start_q;
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_scheduler : scoreboard bench with a behavioural ALU (MUL 5, DIV 9 busy)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode = 4'h0, req1_opcode = 4'h0;
  logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [15:0] rsp0_data, rsp1_data;
  logic        alu_pwr_en, alu_iso_en, alu_start, alu_busy;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result;

  typedef struct {
    int          port;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, start_cnt = 0, rsp_seen = 0, busy_cnt = 0;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_pwr_en(alu_pwr_en), .alu_iso_en(alu_iso_en), .alu_start(alu_start),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_busy(alu_busy), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0: ref_alu = a + b;
      4'h1: ref_alu = a - b;
      4'h2: ref_alu = a & b;
      4'h3: ref_alu = a | b;
      4'h4: ref_alu = a ^ b;
      4'h5: ref_alu = ~(a & b);
      4'h6: ref_alu = ~(a | b);
      4'h7: ref_alu = ~(a ^ b);
      4'h8: ref_alu = a * b;
      4'h9: ref_alu = (b == 16'h0) ? 16'hFFFF : a / b;
      default: ref_alu = 16'hDEAD;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    if (op == 4'h8)      ref_lat = 8;
    else if (op == 4'h9) ref_lat = 12;
    else                 ref_lat = 3;
  endfunction

  // Behavioural ALU: combinational result, busy for a fixed count after start.
  assign alu_result = ref_alu(alu_opcode, alu_a, alu_b);
  assign alu_busy   = (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_start) start_cnt <= start_cnt + 1;
    if (rst)                    busy_cnt <= 0;
    else if (alu_start)         busy_cnt <= (alu_opcode == 4'h8) ? 5 : (alu_opcode == 4'h9) ? 9 : 0;
    else if (busy_cnt > 0)      busy_cnt <= busy_cnt - 1;
  end

  // Response scoreboard and power-sequencing invariant.
  logic        m_v, m_e;
  logic [15:0] m_d;
  exp_t        m_x;
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (!alu_iso_en && !alu_pwr_en) begin
        miscompares++;
        $display("FAIL pwr_iso: pwr_en=%b iso_en=%b at cycle %0d, required pwr_en=1 while iso_en=0", alu_pwr_en, alu_iso_en, cyc);
      end
      for (int p = 0; p < 2; p++) begin
        m_v = (p == 0) ? rsp0_valid : rsp1_valid;
        m_d = (p == 0) ? rsp0_data : rsp1_data;
        m_e = (p == 0) ? rsp0_err : rsp1_err;
        if (m_v) begin
          rsp_seen++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: port %0d data=%h err=%b at cycle %0d, required no response", p, m_d, m_e, cyc);
          end else begin
            m_x = sb.pop_front();
            if (m_x.port !== p || m_x.data !== m_d || m_x.err !== m_e || m_x.cyc !== cyc) begin
              miscompares++;
              $display("FAIL rsp: got port %0d data=%h err=%b cycle %0d, required port %0d data=%h err=%b cycle %0d",
                       p, m_d, m_e, cyc, m_x.port, m_x.data, m_x.err, m_x.cyc);
            end
          end
        end
      end
    end
  end

  task automatic send(input int p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input bit track, input int budget, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    if (p == 0) begin req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; end
    #1;
    n = 0;
    while (((p == 0) ? req0_ready : req1_ready) !== 1'b1) begin
      if (n >= budget) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: port %0d not accepted within %0d cycles, required ready=1", p, budget);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        acc = -1;
        return;
      end
      @(negedge clk);
      #1;
      n++;
    end
    acc = cyc;
    grants.push_back(p);
    if (track) begin
      e.port = p;
      e.data = (op >= 4'hA) ? 16'h0000 : ref_alu(op, a, b);
      e.err  = (op >= 4'hA);
      e.cyc  = cyc + ref_lat(op);
      sb.push_back(e);
    end
    @(negedge clk);
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (alu_pwr_en !== 1'b0 || alu_iso_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_power: pwr_en=%b iso_en=%b, required 0/1", alu_pwr_en, alu_iso_en);
    end
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_start} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: ready/rsp/start=%b, required 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_start});
    end
    vectors++;
    if ({alu_opcode, alu_a, alu_b, rsp0_data, rsp0_err} !== 53'b0) begin
      miscompares++;
      $display("FAIL reset_data: op=%h a=%h b=%h data=%h err=%b, required all 0",
               alu_opcode, alu_a, alu_b, rsp0_data, rsp0_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_cold_start();
    int   s0;
    exp_t e;
    s0 = start_cnt;
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = 4'h0; req0_a = 16'd3; req0_b = 16'd4;
    #1;
    vectors++;
    if (alu_pwr_en !== 1'b0 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_off: pwr_en=%b ready=%b, required 0/0", alu_pwr_en, req0_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if (alu_pwr_en !== 1'b1 || alu_iso_en !== 1'b1) begin
      miscompares++;
      $display("FAIL cold_wake1: pwr_en=%b iso_en=%b, required 1/1", alu_pwr_en, alu_iso_en);
    end
    @(negedge clk); #1;
    vectors++;
    if (alu_iso_en !== 1'b1 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_wake2: iso_en=%b ready=%b, required 1/0", alu_iso_en, req0_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if (alu_iso_en !== 1'b0 || alu_pwr_en !== 1'b1 || req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cold_ready: iso_en=%b pwr_en=%b ready=%b, required 0/1/1", alu_iso_en, alu_pwr_en, req0_ready);
    end
    e.port = 0; e.data = 16'd7; e.err = 1'b0; e.cyc = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    req0_valid = 1'b0;
    drain(20);
    vectors++;
    if (start_cnt !== s0 + 1) begin
      miscompares++;
      $display("FAIL cold_start_pulse: %0d alu_start pulses, required %0d", start_cnt - s0, 1);
    end
  endtask

  task automatic test_both_ports();
    int t0, t1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grants.delete();
    fork
      send(0, 4'h8, 16'd300, 16'd2, 1'b1, 40, t0);
      send(1, 4'h9, 16'd100, 16'd7, 1'b1, 60, t1);
    join
    vectors++;
    if (grants.size() != 2 || grants[0] !== 0) begin
      miscompares++;
      $display("FAIL both_first_grant: size=%0d first=%0d, required size 2 first port 0",
               grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
    vectors++;
    if (t1 !== t0 + 9) begin
      miscompares++;
      $display("FAIL both_second_accept: port1 accepted at %0d, required %0d", t1, t0 + 9);
    end
    drain(40);
  endtask

  task automatic test_fairness();
    int ta, tb_;
    grants.delete();
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(0, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b1, 40, ta);
      end
      begin
        for (int j = 0; j < 3; j++)
          send(1, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b1, 40, tb_);
      end
    join
    vectors++;
    if (grants.size() != 6) begin
      miscompares++;
      $display("FAIL fair_count: %0d grants, required 6", grants.size());
    end
    // Previous grant went to port 1, so the alternation starts at port 0.
    for (int k = 0; k < grants.size(); k++) begin
      vectors++;
      if (grants[k] !== (k % 2)) begin
        miscompares++;
        $display("FAIL fair_order: grant %0d went to port %0d, required port %0d", k, grants[k], k % 2);
      end
    end
    drain(20);
  endtask

  task automatic test_illegal();
    int s0, t;
    s0 = start_cnt;
    send(0, 4'hC, 16'd5, 16'd6, 1'b1, 20, t);
    drain(20);
    send(1, 4'hA, 16'd9, 16'd9, 1'b1, 20, t);
    drain(20);
    vectors++;
    if (start_cnt !== s0) begin
      miscompares++;
      $display("FAIL illegal_start: %0d alu_start pulses, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_idle();
    int t;
    send(1, 4'h1, 16'd50, 16'd8, 1'b1, 20, t);
    while (cyc < t + 19) @(negedge clk);
    #1;
    vectors++;
    if (alu_iso_en !== 1'b0 || alu_pwr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_early: iso_en=%b pwr_en=%b at idle cycle 15, required 0/1", alu_iso_en, alu_pwr_en);
    end
    @(negedge clk); #1;
    vectors++;
    if (alu_iso_en !== 1'b1 || alu_pwr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_isolate: iso_en=%b pwr_en=%b, required 1/1", alu_iso_en, alu_pwr_en);
    end
    @(negedge clk); #1;
    vectors++;
    if (alu_pwr_en !== 1'b0 || alu_iso_en !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_off: pwr_en=%b iso_en=%b, required 0/1", alu_pwr_en, alu_iso_en);
    end
    drain(5);
  endtask

  task automatic test_reset_mid_div();
    int t, r0;
    send(0, 4'h9, 16'd1000, 16'd3, 1'b0, 20, t);
    while (cyc < t + 5) @(negedge clk);
    r0  = rsp_seen;
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (alu_pwr_en !== 1'b0 || alu_iso_en !== 1'b1 || alu_start !== 1'b0 || alu_opcode !== 4'h0) begin
      miscompares++;
      $display("FAIL midrst_state: pwr=%b iso=%b start=%b op=%h, required 0/1/0/0",
               alu_pwr_en, alu_iso_en, alu_start, alu_opcode);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (rsp_seen !== r0) begin
      miscompares++;
      $display("FAIL midrst_rsp: %0d responses after reset, required 0", rsp_seen - r0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_both_ports();
    test_fairness();
    test_illegal();
    test_idle();
    test_reset_mid_div();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_empty: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter: IDLE_TIMEOUT, default 16, consecutive idle READY cycles before power-down.
REQ-002 Parameter: WAKE_CYCLES, default 2, cycles with power on and isolation held before READY.
REQ-003 Parameter: WAIT_LIMIT, default 31, maximum WAIT cycles before a timeout error.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 reqN_valid  in  1  (N=0,1) requester N has an operation pending.
REQ-008 reqN_ready  out  1  requester N accepted this cycle (valid&&ready = accept).
REQ-009 reqN_opcode  in  4  ALU opcode; reqN_a, reqN_b  in  16  operands.
REQ-010 rspN_valid  out  1  one-cycle response pulse to requester N.
REQ-011 rspN_data  out  16  result; rspN_err  out  1  error flag, both qualified by rspN_valid.
REQ-012 alu_pwr_en  out  1  ALU power enable; alu_iso_en  out  1  ALU output isolation.
REQ-013 alu_start  out  1; alu_opcode  out  4; alu_a, alu_b  out  16  ALU command.
REQ-014 alu_busy  in  1; alu_result  in  16  ALU status and result.

Function
REQ-015 FSM states: OFF, WAKE, READY, ISSUE, WAIT, RESP, ISOLATE; all outputs registered.
REQ-016 OFF: alu_pwr_en=0, alu_iso_en=1; any reqN_valid -> WAKE.
REQ-017 WAKE: alu_pwr_en=1, alu_iso_en=1 for WAKE_CYCLES cycles -> READY with alu_iso_en=0.
REQ-018 READY: round-robin arbiter grants one valid port; reqN_ready asserted combinationally for the granted port only.
REQ-019 Both ports valid: grant goes to the port not granted last; pointer updates only on accept.
REQ-020 On accept: capture opcode/A/B into alu_opcode/alu_a/alu_b -> ISSUE; requester tracked for response.
REQ-021 alu_opcode/alu_a/alu_b held stable from ISSUE until RESP exit.
REQ-022 ISSUE: alu_start=1 for exactly one cycle -> WAIT; opcodes 4'b1010-4'b1111 suppress alu_start.
REQ-023 WAIT done: opcode < 4'b1000 -> first WAIT cycle; 4'b1000/4'b1001 -> first cycle alu_busy=0 after alu_busy seen 1.
REQ-024 On done: capture alu_result -> RESP; illegal opcode -> data 16'h0000, err=1.
REQ-025 WAIT exceeding WAIT_LIMIT cycles -> RESP with data 0, err=1.
REQ-026 RESP: rspN_valid=1 one cycle for the owning port, other port 0 -> READY.
REQ-027 Latency from accept cycle T: ADD-class rsp_valid at T+3; MUL at T+8; DIV at T+12.
REQ-028 READY with no reqN_valid for IDLE_TIMEOUT consecutive cycles -> ISOLATE; any valid clears the counter.
REQ-029 ISOLATE: alu_iso_en=1, alu_pwr_en=1 one cycle -> OFF; requests arriving then wait in OFF for wake.
REQ-030 alu_pwr_en never falls while alu_iso_en=0; alu_iso_en never falls before WAKE completes.
REQ-031 Only one operation outstanding; no reqN_ready outside READY.

Reset
REQ-032 rst overrides all: state OFF, alu_pwr_en=0, alu_iso_en=1, all other outputs 0.
REQ-033 Reset mid-operation: in-flight operation discarded, no rsp pulse; RR pointer favours port 0.

Structure
REQ-034 Shared package alu_sched_pkg: FSM state enum, ALU opcode constants (ADD..XNOR, MUL 4'b1000, DIV 4'b1001), parameter defaults.
REQ-035 One sub-module: rr_arb2 (two-port round-robin arbiter with pointer update on accept).

Verification
REQ-036 Cold start: req0 ADD A=3 B=4 in OFF -> pwr_en rises next cycle, iso falls after 2 cycles, rsp0_data=7 err=0.
REQ-037 Both ports valid in READY: req0 MUL 300*2, req1 DIV 100/7 -> rsp0=600 at T+8, then rsp1=14 at T+12 of its accept.
REQ-038 Fairness: both ports continuously valid with ADDs -> grants alternate 0,1,0,1; no port starves.
REQ-039 Illegal opcode 4'b1100 -> alu_start never pulses, rsp err=1 data 0 at T+3.
REQ-040 Idle 16 cycles in READY -> iso rises, pwr_en falls one cycle later; reset during DIV WAIT -> OFF, no rsp.
